// File: rtl/serial_add_pkg.sv
// ----------------------------------------------------------------------------
// serial_add_pkg
//   Shared types and helpers for the bit-serial adder stage.
//   - state_t       : controller state (IDLE / RUN / DONE), 2-bit encoding
//   - DEFAULT_WIDTH : default operand width
//   - cnt_width()   : width of the bit counter that indexes 0..WIDTH-1
// ----------------------------------------------------------------------------
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // The counter only needs to reach WIDTH-1. Keep at least one bit so
    // WIDTH=2 still gets a real register.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// ----------------------------------------------------------------------------
// fa_cell
//   Single-bit combinational full adder. This is the only arithmetic cell in
//   the serial adder; every sum bit passes through it.
// Ports:
//   a, b   in  1  addend bits
//   cin    in  1  carry in
//   s      out 1  sum bit
//   cout   out 1  carry out
// ----------------------------------------------------------------------------
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder stage. On an accepted start the operands and carry-in are
//   captured; one bit pair per clock (LSB first) is then fed through a single
//   fa_cell and the sum is reassembled in a shift register. The result is
//   published together with a one-cycle done pulse and held until the next
//   accepted start.
//
//   A start accepted at edge N produces done in the cycle after edge N+WIDTH.
//   start is sampled only in IDLE or DONE; the DONE cycle can accept the next
//   operation directly, so back-to-back operations leave no idle cycle.
//
// Configuration:
//   SERIAL_ADD_OVF_EN  when defined, adds the ovf port (signed overflow,
//                      registered and held with sum). Undefined: no ovf port.
//
// Parameters:
//   WIDTH      operand/sum width, >= 2
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      operation request
//   a, b       in   WIDTH  operands, captured on accepted start
//   carry_in   in   1      carry-in, captured on accepted start
//   busy       out  1      high while bits are being processed (RUN)
//   done       out  1      one-cycle pulse, result valid
//   sum        out  WIDTH  result (held)
//   carry_out  out  1      carry out of the MSB (held)
//   ovf        out  1      signed overflow (SERIAL_ADD_OVF_EN only)
// ----------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_accept;
    logic                 w_last;

    logic [WIDTH-1:0]     r_a_sh;
    logic [WIDTH-1:0]     r_b_sh;
    logic [WIDTH-2:0]     r_sum_sh;
    logic                 r_c;
    logic [CW-1:0]        r_cnt;

    logic                 r_done;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_cout;

    logic                 w_s;
    logic                 w_cout;
    logic [WIDTH-1:0]     w_sum_next;

    fa_cell u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_c),
        .s    (w_s),
        .cout (w_cout)
    );

    // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    // On the last RUN edge this is the complete sum.
    assign w_sum_next = {w_s, r_sum_sh};

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: state and datapath registers use non-blocking assignment so every
    // flop samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state / decode
    // ------------------------------------------------------------------
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == LAST) begin
                    w_last       = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: capture, serial shift, result publication
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_a_sh <= a;
                r_b_sh <= b;
                r_c    <= carry_in;
                r_cnt  <= '0;
            end else if (r_state == ST_RUN) begin
                r_a_sh   <= r_a_sh >> 1;
                r_b_sh   <= r_b_sh >> 1;
                r_sum_sh <= w_sum_next[WIDTH-1:1];
                r_c      <= w_cout;
                r_cnt    <= r_cnt + CW'(1);
            end
            if (w_last) begin
                r_sum  <= w_sum_next;
                r_cout <= w_cout;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;

    // On the last RUN edge r_c is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_c ^ w_cout;
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy      = (r_state == ST_RUN);
    assign done      = r_done;
    assign sum       = r_sum;
    assign carry_out = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serial_add_ctrl
//   Scoreboard bench for serial_add_ctrl. The driver pushes the expected
//   result of every accepted operation into a queue; a monitor pops and
//   compares each time done is seen. Expected values come from plain integer
//   arithmetic on the operands.
//   Define SERIAL_ADD_OVF_EN to build and check the ovf output as well.
// ----------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   total = 0;
    int   bad   = 0;
    int   n_issued = 0;
    int   n_done   = 0;
    int   last_done_cyc = -100;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: integer addition; signed overflow from the signed range.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        exp_t        m;
        int unsigned u;
        int          s;
        u = 32'(ta) + 32'(tb) + 32'(tc);
        s = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
        m.sum     = u[W-1:0];
        m.cout    = u[W];
        m.ovf     = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
        m.acc_cyc = 0;
        return m;
    endfunction

    // Monitor: every done must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_done++;
                last_done_cyc = cyc;
                check("sum",       32'(sum),       32'(e.sum));
                check("carry_out", 32'(carry_out), 32'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
                check("ovf",       32'(ovf),       32'(e.ovf));
`endif
                check("latency",   32'(cyc - e.acc_cyc), 32'(W));
            end
        end
    end

    // Drive an operation once the DUT is accepting (busy low at a falling
    // edge means the next rising edge accepts). hold leaves start high.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input bit hold, input bit chk_gap);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        while (busy && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (busy) begin
            check("issue_timeout", 32'(busy), 32'd0);
            return;
        end
        a        = ta;
        b        = tb;
        carry_in = tc;
        start    = 1'b1;
        @(posedge clk);
        #1;
        e         = model(ta, tb, tc);
        e.acc_cyc = cyc;
        sb.push_back(e);
        n_issued++;
        check("busy_after_accept", 32'(busy), 32'd1);
        if (chk_gap) check("b2b_gap", 32'(cyc - last_done_cyc), 32'd1);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        carry_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(carry_out), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf",  32'(ovf),  32'd0);
`endif
        rst_n = 1'b1;

        // Directed operations, including the overflow corner cases.
        issue(4'd2,  4'd3,  1'b0, 0, 0);
        issue(4'd1,  4'd7,  1'b0, 0, 0);
        issue(4'd15, 4'd15, 1'b1, 0, 0);
        issue(4'd7,  4'd1,  1'b0, 0, 0);
        issue(4'd8,  4'd8,  1'b0, 0, 0);
        wait_drain();

        // Result is held after done.
        repeat (3) @(negedge clk);
        check("hold_sum",  32'(sum),       32'd0);
        check("hold_cout", 32'(carry_out), 32'd1);

        // Back-to-back: start held through RUN, accepted in the DONE cycle.
        issue(4'd15, 4'd1, 1'b0, 1, 0);
        issue(4'd3,  4'd4, 1'b0, 0, 1);
        wait_drain();

        // start and operand changes while busy are ignored.
        issue(4'd5, 4'd6, 1'b1, 0, 0);
        repeat (2) begin
            @(negedge clk);
            start    = 1'b1;
            a        = 4'($urandom_range(0, 15));
            b        = 4'($urandom_range(0, 15));
            carry_in = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        check("ignored_no_extra", 32'(busy), 32'd0);

        // Randomized operations with random gaps and back-to-back holds.
        for (int i = 0; i < 40; i++) begin
            issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0);
            if (!start) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        issue(4'd2, 4'd3, 1'b0, 0, 0);
        wait_drain();

        // Reset two cycles into RUN: outputs clear at once, no done follows.
        issue(4'd9, 4'd9, 1'b1, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum",  32'(sum),  32'd0);
        check("abort_cout", 32'(carry_out), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("abort_ovf",  32'(ovf),  32'd0);
`endif
        sb.delete();
        n_issued--;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * W) @(negedge clk);
        check("abort_idle", 32'(busy), 32'd0);

        // Normal operation resumes after the abort.
        issue(4'd6, 4'd9, 1'b1, 0, 0);
        wait_drain();
        repeat (3) @(negedge clk);
        check("done_count", 32'(n_done), 32'(n_issued));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
